// File: rtl/pipe_control_unit.sv
// pipe_control_unit: RV32I control unit for a 5-stage pipeline.
// Decodes instrD in ID, then carries the control bundle and rd through the
// ID/EX, EX/MEM and MEM/WB registers. Branches and jumps resolve in EX.
// Optional feature macro: PIPE_CTRL_ILLEGAL_EN adds the sticky illegalE output.
//
// Handshake: there is none. Every pipeline register loads on every rising
// edge; rst clears all stages; flushE replaces only the ID/EX contents with a
// bubble on the same edge. rst wins over flushE.
module pipe_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter int RD_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instrD,
    input  logic                  flushE,
    input  logic                  zeroE,
    input  logic                  ltE,
    input  logic                  ltuE,
    output logic [IMM_SRC_W-1:0]  immSrcD,
    output logic [ALU_CTRL_W-1:0] aluControlE,
    output logic                  aluSrcE,
    output logic                  pcSrcE,
    output logic                  jalrE,
    output logic                  regWriteM,
    output logic                  regWriteW,
    output logic                  memWriteM,
    output logic [1:0]            resultSrcE,
    output logic [1:0]            resultSrcW,
    output logic [RD_W-1:0]       rdE,
    output logic [RD_W-1:0]       rdM,
    output logic [RD_W-1:0]       rdW
`ifdef PIPE_CTRL_ILLEGAL_EN
    ,
    output logic                  illegalE
`endif
);

    // Opcodes handled by the decoder.
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_IALU   = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    // ALU operation codes.
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(9);

    // Internal ALU operation class produced by the main decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Instruction fields.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;

    assign opcode    = instrD[6:0];
    assign funct3    = instrD[14:12];
    assign funct7_b5 = instrD[30];

    // Decoded (ID) control bundle, next-state for the ID/EX register.
    logic                  reg_write_d;
    logic                  mem_write_d;
    logic                  branch_d;
    logic                  jump_d;
    logic                  jalr_d;
    logic                  alu_src_d;
    logic [1:0]            result_src_d;
    logic [IMM_SRC_W-1:0]  imm_src_d;
    logic [1:0]            alu_op_d;
    logic [ALU_CTRL_W-1:0] alu_control_d;
    logic [RD_W-1:0]       rd_d;
    logic                  illegal_d;

    // Main decoder: opcode to control bundle; unknown opcodes and the two
    // reserved branch funct3 codes decode as a bubble.
    always_comb begin
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        jalr_d       = 1'b0;
        alu_src_d    = 1'b0;
        result_src_d = 2'b00;
        imm_src_d    = IMM_SRC_W'(0);
        alu_op_d     = ALUOP_ADD;
        illegal_d    = 1'b0;
        case (opcode)
            OP_LOAD: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                imm_src_d    = IMM_SRC_W'(0);
                result_src_d = 2'b01;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                alu_src_d   = 1'b1;
                imm_src_d   = IMM_SRC_W'(1);
            end
            OP_RTYPE: begin
                reg_write_d = 1'b1;
                alu_op_d    = ALUOP_FUNCT;
            end
            OP_IALU: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op_d    = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    illegal_d = 1'b1;
                end else begin
                    branch_d  = 1'b1;
                    imm_src_d = IMM_SRC_W'(2);
                    alu_op_d  = ALUOP_SUB;
                end
            end
            OP_JAL: begin
                reg_write_d  = 1'b1;
                jump_d       = 1'b1;
                imm_src_d    = IMM_SRC_W'(3);
                result_src_d = 2'b10;
            end
            OP_JALR: begin
                reg_write_d  = 1'b1;
                jump_d       = 1'b1;
                jalr_d       = 1'b1;
                alu_src_d    = 1'b1;
                imm_src_d    = IMM_SRC_W'(0);
                result_src_d = 2'b10;
            end
            OP_LUI: begin
                reg_write_d  = 1'b1;
                imm_src_d    = IMM_SRC_W'(4);
                result_src_d = 2'b11;
            end
            default: begin
                illegal_d = 1'b1;
            end
        endcase
    end

    // ALU decoder: funct3/funct7 select the operation for R-type and I-ALU.
    always_comb begin
        alu_control_d = ALU_ADD;
        case (alu_op_d)
            ALUOP_ADD: alu_control_d = ALU_ADD;
            ALUOP_SUB: alu_control_d = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi ignores funct7; only R-type can subtract.
                    3'b000:  alu_control_d = (opcode == OP_RTYPE && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control_d = ALU_SLL;
                    3'b010:  alu_control_d = ALU_SLT;
                    3'b011:  alu_control_d = ALU_SLTU;
                    3'b100:  alu_control_d = ALU_XOR;
                    3'b101:  alu_control_d = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control_d = ALU_OR;
                    default: alu_control_d = ALU_AND;
                endcase
            end
            default: alu_control_d = ALU_ADD;
        endcase
    end

    // rd is only meaningful when the instruction writes the register file.
    assign rd_d    = reg_write_d ? RD_W'(instrD[11:7]) : RD_W'(0);
    assign immSrcD = imm_src_d;

    // ID/EX register.
    logic                  reg_write_e_q;
    logic                  mem_write_e_q;
    logic                  branch_e_q;
    logic                  jump_e_q;
    logic                  jalr_e_q;
    logic                  alu_src_e_q;
    logic [1:0]            result_src_e_q;
    logic [ALU_CTRL_W-1:0] alu_control_e_q;
    logic [2:0]            funct3_e_q;
    logic [RD_W-1:0]       rd_e_q;

    // ID/EX: load the decoded bundle, or a bubble on reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            reg_write_e_q   <= 1'b0;
            mem_write_e_q   <= 1'b0;
            branch_e_q      <= 1'b0;
            jump_e_q        <= 1'b0;
            jalr_e_q        <= 1'b0;
            alu_src_e_q     <= 1'b0;
            result_src_e_q  <= 2'b00;
            alu_control_e_q <= ALU_ADD;
            funct3_e_q      <= 3'b000;
            rd_e_q          <= RD_W'(0);
        end else begin
            reg_write_e_q   <= reg_write_d;
            mem_write_e_q   <= mem_write_d;
            branch_e_q      <= branch_d;
            jump_e_q        <= jump_d;
            jalr_e_q        <= jalr_d;
            alu_src_e_q     <= alu_src_d;
            result_src_e_q  <= result_src_d;
            alu_control_e_q <= alu_control_d;
            funct3_e_q      <= funct3;
            rd_e_q          <= rd_d;
        end
    end

`ifdef PIPE_CTRL_ILLEGAL_EN
    logic illegal_e_q;

    // Sticky illegal flag: set by a non-flushed illegal decode, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_e_q <= 1'b0;
        end else if (illegal_d && !flushE) begin
            illegal_e_q <= 1'b1;
        end
    end

    assign illegalE = illegal_e_q;
`else
    // Without the feature an illegal instruction is simply a bubble.
    logic unused_illegal;
    assign unused_illegal = illegal_d;
`endif

    // Branch condition selected by the funct3 held in ID/EX.
    logic branch_cond_e;

    // Evaluate the branch condition from the EX-stage ALU flags.
    always_comb begin
        branch_cond_e = 1'b0;
        case (funct3_e_q)
            3'b000:  branch_cond_e = zeroE;
            3'b001:  branch_cond_e = ~zeroE;
            3'b100:  branch_cond_e = ltE;
            3'b101:  branch_cond_e = ~ltE;
            3'b110:  branch_cond_e = ltuE;
            3'b111:  branch_cond_e = ~ltuE;
            default: branch_cond_e = 1'b0;
        endcase
    end

    assign pcSrcE      = jump_e_q | (branch_e_q & branch_cond_e);
    assign aluControlE = alu_control_e_q;
    assign aluSrcE     = alu_src_e_q;
    assign jalrE       = jalr_e_q;
    assign resultSrcE  = result_src_e_q;
    assign rdE         = rd_e_q;

    // EX/MEM register.
    logic            reg_write_m_q;
    logic            mem_write_m_q;
    logic [1:0]      result_src_m_q;
    logic [RD_W-1:0] rd_m_q;

    // EX/MEM: advance every edge; flushE leaves this stage alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= 2'b00;
            rd_m_q         <= RD_W'(0);
        end else begin
            reg_write_m_q  <= reg_write_e_q;
            mem_write_m_q  <= mem_write_e_q;
            result_src_m_q <= result_src_e_q;
            rd_m_q         <= rd_e_q;
        end
    end

    assign regWriteM = reg_write_m_q;
    assign memWriteM = mem_write_m_q;
    assign rdM       = rd_m_q;

    // MEM/WB register.
    logic            reg_write_w_q;
    logic [1:0]      result_src_w_q;
    logic [RD_W-1:0] rd_w_q;

    // MEM/WB: advance every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 2'b00;
            rd_w_q         <= RD_W'(0);
        end else begin
            reg_write_w_q  <= reg_write_m_q;
            result_src_w_q <= result_src_m_q;
            rd_w_q         <= rd_m_q;
        end
    end

    assign regWriteW  = reg_write_w_q;
    assign resultSrcW = result_src_w_q;
    assign rdW        = rd_w_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: directed and randomized checks of pipe_control_unit.
// Reference model: an instruction decoded from the opcode tables, and a
// history queue of decoded bundles where entry 0 is in EX, 1 in MEM, 2 in WB.
module tb_pipe_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instrD;
  logic        flushE;
  logic        zeroE;
  logic        ltE;
  logic        ltuE;
  logic [2:0]  immSrcD;
  logic [3:0]  aluControlE;
  logic        aluSrcE;
  logic        pcSrcE;
  logic        jalrE;
  logic        regWriteM;
  logic        regWriteW;
  logic        memWriteM;
  logic [1:0]  resultSrcE;
  logic [1:0]  resultSrcW;
  logic [4:0]  rdE;
  logic [4:0]  rdM;
  logic [4:0]  rdW;
`ifdef PIPE_CTRL_ILLEGAL_EN
  logic        illegalE;
`endif

  int compared;
  int mismatched;

  pipe_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instrD      (instrD),
    .flushE      (flushE),
    .zeroE       (zeroE),
    .ltE         (ltE),
    .ltuE        (ltuE),
    .immSrcD     (immSrcD),
    .aluControlE (aluControlE),
    .aluSrcE     (aluSrcE),
    .pcSrcE      (pcSrcE),
    .jalrE       (jalrE),
    .regWriteM   (regWriteM),
    .regWriteW   (regWriteW),
    .memWriteM   (memWriteM),
    .resultSrcE  (resultSrcE),
    .resultSrcW  (resultSrcW),
    .rdE         (rdE),
    .rdM         (rdM),
    .rdW         (rdW)
`ifdef PIPE_CTRL_ILLEGAL_EN
    ,
    .illegalE    (illegalE)
`endif
  );

  // Clock / reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rw;
    logic       mw;
    logic       br;
    logic       jp;
    logic       jr;
    logic       asrc;
    logic [1:0] res;
    logic [3:0] alu;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [2:0] imm;
    logic       ill;
  } ctl_t;

  ctl_t hist[$];
  logic exp_ill;

  function automatic ctl_t bubble();
    ctl_t c;
    c.rw = 0; c.mw = 0; c.br = 0; c.jp = 0; c.jr = 0; c.asrc = 0;
    c.res = 0; c.alu = 0; c.f3 = 0; c.rd = 0; c.imm = 0; c.ill = 0;
    return c;
  endfunction

  // ALU code for the funct3-selected ops; sub/sra keyed on instruction bit 30.
  function automatic logic [3:0] alu_sel(logic [2:0] f3, logic b30, logic is_r);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_r && b30) return 4'd1;
    if (f3 == 3'd5 && b30) return 4'd9;
    return tbl[f3];
  endfunction

  function automatic ctl_t ref_decode(logic [31:0] ins);
    ctl_t c;
    logic [2:0] f3;
    c = bubble();
    f3 = ins[14:12];
    case (ins[6:0])
      7'h03: begin c.rw = 1; c.asrc = 1; c.res = 1; end
      7'h23: begin c.mw = 1; c.asrc = 1; c.imm = 1; end
      7'h33: begin c.rw = 1; c.alu = alu_sel(f3, ins[30], 1'b1); end
      7'h13: begin c.rw = 1; c.asrc = 1; c.alu = alu_sel(f3, ins[30], 1'b0); end
      7'h63: begin
        if (f3 == 3'd2 || f3 == 3'd3) c.ill = 1;
        else begin c.br = 1; c.imm = 2; c.alu = 1; c.f3 = f3; end
      end
      7'h6F: begin c.rw = 1; c.jp = 1; c.imm = 3; c.res = 2; end
      7'h67: begin c.rw = 1; c.jp = 1; c.jr = 1; c.asrc = 1; c.res = 2; end
      7'h37: begin c.rw = 1; c.imm = 4; c.res = 3; end
      default: c.ill = 1;
    endcase
    if (c.rw) c.rd = ins[11:7];
    return c;
  endfunction

  function automatic logic ref_pcsrc(ctl_t c, logic z, logic lt, logic ltu);
    logic taken;
    case (c.f3)
      3'd0: taken = z;
      3'd1: taken = !z;
      3'd4: taken = lt;
      3'd5: taken = !lt;
      3'd6: taken = ltu;
      3'd7: taken = !ltu;
      default: taken = 0;
    endcase
    return c.jp || (c.br && taken);
  endfunction

  // Scoreboard comparison.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: apply one instruction for one clock and advance the model.
  task automatic step(input logic [31:0] ins, input logic fl, input logic rs);
    ctl_t d;
    instrD = ins;
    flushE = fl;
    rst    = rs;
    #1;
    d = ref_decode(ins);
    check("immSrcD", {29'd0, immSrcD}, {29'd0, d.imm});
    @(posedge clk);
    #1;
    if (rs) begin
      hist.delete();
      repeat (3) hist.push_front(bubble());
      exp_ill = 0;
    end else begin
      if (!fl && d.ill) exp_ill = 1;
      hist.push_front(fl ? bubble() : d);
      void'(hist.pop_back());
    end
    rst = 0;
    flushE = 0;
  endtask

  // Compare every registered output and pcSrcE against the model.
  task automatic check_all(input string tag);
    check({tag, ".aluControlE"}, {28'd0, aluControlE}, {28'd0, hist[0].alu});
    check({tag, ".aluSrcE"}, {31'd0, aluSrcE}, {31'd0, hist[0].asrc});
    check({tag, ".jalrE"}, {31'd0, jalrE}, {31'd0, hist[0].jr});
    check({tag, ".resultSrcE"}, {30'd0, resultSrcE}, {30'd0, hist[0].res});
    check({tag, ".rdE"}, {27'd0, rdE}, {27'd0, hist[0].rd});
    check({tag, ".pcSrcE"}, {31'd0, pcSrcE}, {31'd0, ref_pcsrc(hist[0], zeroE, ltE, ltuE)});
    check({tag, ".regWriteM"}, {31'd0, regWriteM}, {31'd0, hist[1].rw});
    check({tag, ".memWriteM"}, {31'd0, memWriteM}, {31'd0, hist[1].mw});
    check({tag, ".rdM"}, {27'd0, rdM}, {27'd0, hist[1].rd});
    check({tag, ".regWriteW"}, {31'd0, regWriteW}, {31'd0, hist[2].rw});
    check({tag, ".resultSrcW"}, {30'd0, resultSrcW}, {30'd0, hist[2].res});
    check({tag, ".rdW"}, {27'd0, rdW}, {27'd0, hist[2].rd});
`ifdef PIPE_CTRL_ILLEGAL_EN
    check({tag, ".illegalE"}, {31'd0, illegalE}, {31'd0, exp_ill});
`endif
  endtask

  task automatic set_flags(input logic z, input logic lt, input logic ltu);
    zeroE = z;
    ltE   = lt;
    ltuE  = ltu;
    #1;
  endtask

  localparam logic [31:0] I_LW   = 32'h0002A283;
  localparam logic [31:0] I_SW   = 32'h00B52023;
  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_SRAI = 32'h40355513;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_BNE  = 32'h00001063;
  localparam logic [31:0] I_BGE  = 32'h00005063;
  localparam logic [31:0] I_BLTU = 32'h00006063;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  initial begin
    logic [6:0] ops [10];
    logic [31:0] r;
    compared   = 0;
    mismatched = 0;
    exp_ill    = 0;
    instrD = 0; flushE = 0; rst = 1;
    zeroE = 0; ltE = 0; ltuE = 0;
    repeat (3) hist.push_front(bubble());
    @(negedge clk);

    // Reset state.
    step(I_LW, 1'b0, 1'b1);
    step(I_LW, 1'b0, 1'b1);
    check_all("reset");
    check("reset.pcSrcE", {31'd0, pcSrcE}, 32'd0);
    check("reset.regWriteW", {31'd0, regWriteW}, 32'd0);

    // lw x5 latency.
    step(I_LW, 1'b0, 1'b0);
    check("lw.aluSrcE", {31'd0, aluSrcE}, 32'd1);
    check("lw.resultSrcE", {30'd0, resultSrcE}, 32'd1);
    check("lw.rdE", {27'd0, rdE}, 32'd5);
    step(I_NOP, 1'b0, 1'b0);
    check("lw.regWriteM", {31'd0, regWriteM}, 32'd1);
    step(I_NOP, 1'b0, 1'b0);
    check("lw.regWriteW", {31'd0, regWriteW}, 32'd1);
    check("lw.resultSrcW", {30'd0, resultSrcW}, 32'd1);
    check("lw.rdW", {27'd0, rdW}, 32'd5);
    check_all("lw");

    // Branch resolution.
    step(I_BEQ, 1'b0, 1'b0);
    set_flags(1, 0, 0); check("beq_taken", {31'd0, pcSrcE}, 32'd1);
    set_flags(0, 0, 0); check("beq_not", {31'd0, pcSrcE}, 32'd0);
    step(I_BNE, 1'b0, 1'b0);
    set_flags(0, 0, 0); check("bne_taken", {31'd0, pcSrcE}, 32'd1);
    step(I_BLTU, 1'b0, 1'b0);
    set_flags(0, 0, 1); check("bltu_taken", {31'd0, pcSrcE}, 32'd1);
    step(I_BGE, 1'b0, 1'b0);
    set_flags(0, 1, 0); check("bge_not", {31'd0, pcSrcE}, 32'd0);
    check_all("bge");

    // ALU control.
    step(I_SUB, 1'b0, 1'b0);
    check("sub.alu", {28'd0, aluControlE}, 32'd1);
    step(I_SRAI, 1'b0, 1'b0);
    check("srai.alu", {28'd0, aluControlE}, 32'd9);
    step(I_ADD, 1'b0, 1'b0);
    check("add.alu", {28'd0, aluControlE}, 32'd0);

    // Flush: jal squashed while an older sw completes.
    step(I_SW, 1'b0, 1'b0);
    step(I_JAL, 1'b1, 1'b0);
    check("flush.pcSrcE", {31'd0, pcSrcE}, 32'd0);
    check("flush.rdE", {27'd0, rdE}, 32'd0);
    check("flush.memWriteM", {31'd0, memWriteM}, 32'd1);

    // Reset mid-operation with lw in M and jal in E.
    step(I_LW, 1'b0, 1'b0);
    step(I_JAL, 1'b0, 1'b0);
    check("pre_rst.pcSrcE", {31'd0, pcSrcE}, 32'd1);
    step(I_JAL, 1'b0, 1'b1);
    check("rst.regWriteM", {31'd0, regWriteM}, 32'd0);
    check("rst.pcSrcE", {31'd0, pcSrcE}, 32'd0);
    check("rst.regWriteW", {31'd0, regWriteW}, 32'd0);
    check("rst.resultSrcW", {30'd0, resultSrcW}, 32'd0);
    check("rst.rdW", {27'd0, rdW}, 32'd0);

`ifdef PIPE_CTRL_ILLEGAL_EN
    step(32'h0000007F, 1'b0, 1'b0);
    check("illegal.set", {31'd0, illegalE}, 32'd1);
    step(I_NOP, 1'b0, 1'b0);
    check("illegal.sticky", {31'd0, illegalE}, 32'd1);
    step(I_NOP, 1'b0, 1'b1);
    check("illegal.rst", {31'd0, illegalE}, 32'd0);
    step(32'h0000007F, 1'b1, 1'b0);
    check("illegal.flushed", {31'd0, illegalE}, 32'd0);
`endif

    // Randomized stream against the reference model.
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F, 7'h00};
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      step(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 39) == 0));
      set_flags(1'($urandom), 1'($urandom), 1'($urandom));
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
